// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned BCD_W      = DIGIT_W * NUM_DIGITS;

  localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'hF;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  typedef struct packed {
    logic [DIGIT_W-1:0] thousand;
    logic [DIGIT_W-1:0] hundred;
    logic [DIGIT_W-1:0] ten;
    logic [DIGIT_W-1:0] one;
  } bcd_digits_t;

  // Replace leading zero digits above the ones digit with the blank code.
  function automatic bcd_digits_t blank_leading(input bcd_digits_t d);
    bcd_digits_t r;
    r = d;
    if (d.thousand == '0) begin
      r.thousand = BLANK_CODE;
      if (d.hundred == '0) begin
        r.hundred = BLANK_CODE;
        if (d.ten == '0) r.ten = BLANK_CODE;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Start/busy/done handshake and digit bus between producer and converter.
interface bin_to_bcd_seq_if
  import bcd_pkg::*;
#(
  parameter int unsigned W = 12
);
  logic               start;
  logic [W-1:0]       bin;
  logic               busy;
  logic               done;
  logic [DIGIT_W-1:0] one;
  logic [DIGIT_W-1:0] ten;
  logic [DIGIT_W-1:0] hundred;
  logic [DIGIT_W-1:0] thousand;

  modport master (
    output start, bin,
    input  busy, done, one, ten, hundred, thousand
  );

  modport slave (
    input  start, bin,
    output busy, done, one, ten, hundred, thousand
  );
endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction cell: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] adj_c
);

  always_comb begin
    adj_c = (digit >= DIGIT_W'(5)) ? digit + DIGIT_W'(3) : digit;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock.
// Optional feature: BCD_LEADING_BLANK_EN blanks leading zero digits.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned W = 12
) (
  input  logic             clk,
  input  logic             rst,
  bin_to_bcd_seq_if.slave  bus
);

  localparam int unsigned CNT_W = (W > 1) ? $clog2(W) : 1;

  state_t             state, state_n;
  logic [W-1:0]       sr, sr_n;
  logic [BCD_W-1:0]   scratch, scratch_n;
  logic [BCD_W-1:0]   adj_c;
  logic [BCD_W-1:0]   shifted_c;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               busy, busy_n;
  logic               done, done_n;
  bcd_digits_t        digits, digits_n;
  bcd_digits_t        result_c;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit (scratch[g*DIGIT_W +: DIGIT_W]),
      .adj_c (adj_c[g*DIGIT_W +: DIGIT_W])
    );
  end

  // Adjusted scratch shifted left with the next binary bit entering at the bottom.
  assign shifted_c = BCD_W'({adj_c, sr[W-1]});

`ifdef BCD_LEADING_BLANK_EN
  assign result_c = blank_leading(bcd_digits_t'(shifted_c));
`else
  assign result_c = bcd_digits_t'(shifted_c);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sr      <= '0;
      scratch <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      digits  <= '0;
    end else begin
      state   <= state_n;
      sr      <= sr_n;
      scratch <= scratch_n;
      cnt     <= cnt_n;
      busy    <= busy_n;
      done    <= done_n;
      digits  <= digits_n;
    end
  end

  always_comb begin
    state_n   = state;
    sr_n      = sr;
    scratch_n = scratch;
    cnt_n     = cnt;
    busy_n    = busy;
    done_n    = 1'b0;
    digits_n  = digits;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_n   = SHIFT;
          sr_n      = bus.bin;
          scratch_n = '0;
          cnt_n     = '0;
          busy_n    = 1'b1;
        end
      end
      SHIFT: begin
        sr_n      = sr << 1;
        scratch_n = shifted_c;
        cnt_n     = cnt + CNT_W'(1);
        // Last bit: publish digits and hand control back to IDLE.
        if (cnt == CNT_W'(W - 1)) begin
          state_n  = IDLE;
          busy_n   = 1'b0;
          done_n   = 1'b1;
          digits_n = result_c;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.one      = digits.one;
  assign bus.ten      = digits.ten;
  assign bus.hundred  = digits.hundred;
  assign bus.thousand = digits.thousand;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: directed starts push expected digits, a monitor checks each done.
module tb_bin_to_bcd_seq;

  localparam int unsigned W = 12;
`ifdef BCD_LEADING_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic clk;
  logic rst;

  bin_to_bcd_seq_if #(.W(W)) bus ();

  bin_to_bcd_seq #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          busy_run = 0;
  bit          done_prev = 1'b0;
  logic [15:0] exp_q[$];
  int          stc_q[$];
  logic [15:0] last_exp = 16'h0000;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] act_digits();
    return {bus.thousand, bus.hundred, bus.ten, bus.one};
  endfunction

  // Monitor: every done pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    logic [15:0] e;
    int          s;
    if (rst) begin
      busy_run  = 0;
      done_prev = 1'b0;
    end else begin
      if (bus.busy) busy_run++;
      if (bus.done) begin
        checks++;
        if (done_prev) begin
          errors++;
          $display("FAIL done_twice: done high on two consecutive cycles at cycle %0d", cyc);
        end
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: digits %h at cycle %0d, no conversion pending", act_digits(), cyc);
        end else begin
          e = exp_q.pop_front();
          s = stc_q.pop_front();
          checks++;
          if (act_digits() !== e) begin
            errors++;
            $display("FAIL digits: got %h expected %h", act_digits(), e);
          end
          checks++;
          if (cyc - s != int'(W) + 1) begin
            errors++;
            $display("FAIL latency: got %0d expected %0d", cyc - s, W + 1);
          end
          checks++;
          if (busy_run != int'(W)) begin
            errors++;
            $display("FAIL busy_len: got %0d expected %0d", busy_run, W);
          end
          last_exp = e;
        end
        busy_run = 0;
      end
      done_prev = bus.done;
    end
  end

  // Drive start for one cycle from a negedge; optionally register the expected result.
  task automatic issue(input logic [W-1:0] v, input logic [15:0] plain,
                       input logic [15:0] blanked, input bit expect_done);
    bus.start = 1'b1;
    bus.bin   = v;
    if (expect_done) begin
      exp_q.push_back(BLANK ? blanked : plain);
      stc_q.push_back(cyc);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: %0d results still pending after %0d cycles", name, exp_q.size(), n);
      exp_q.delete();
      stc_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_hold(input string name);
    checks++;
    if (act_digits() !== last_exp || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL hold_%s: digits %h busy %b done %b expected digits %h busy 0 done 0",
               name, act_digits(), bus.busy, bus.done, last_exp);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.bin   = '0;
    rst       = 1'b1;
    repeat (2) @(negedge clk);
    check_hold("reset");
    rst = 1'b0;
    @(negedge clk);

    issue(12'd255, 16'h0255, 16'hF255, 1'b1);
    wait_idle("255");
    check_hold("after_255");

    issue(12'd0, 16'h0000, 16'hFFF0, 1'b1);
    wait_idle("0");
    issue(12'd4095, 16'h4095, 16'h4095, 1'b1);
    wait_idle("4095");
    issue(12'd1000, 16'h1000, 16'h1000, 1'b1);
    wait_idle("1000");
    check_hold("after_1000");

    // Second start arrives while busy and must be dropped.
    issue(12'd77, 16'h0077, 16'hFF77, 1'b1);
    repeat (2) @(negedge clk);
    issue(12'd12, 16'h0012, 16'hFF12, 1'b0);
    bus.bin = 12'd3000;
    wait_idle("77");
    repeat (20) @(negedge clk);
    check_hold("ignored_start");

    // Reset during a conversion discards it and zeroes the digits.
    issue(12'd999, 16'h0999, 16'hF999, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    last_exp = 16'h0000;
    check_hold("mid_reset");
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_hold("post_reset");

    issue(12'd42, 16'h0042, 16'hFF42, 1'b1);
    wait_idle("42");

    // Back-to-back: next start in the done cycle of the previous conversion.
    issue(12'd100, 16'h0100, 16'hF100, 1'b1);
    begin
      int n;
      n = 0;
      while (bus.done !== 1'b1 && n < 30) begin
        @(negedge clk);
        n++;
      end
    end
    if (bus.done === 1'b1) begin
      issue(12'd7, 16'h0007, 16'hFFF7, 1'b1);
    end else begin
      checks++;
      errors++;
      $display("FAIL b2b_done: done not seen, got %b expected 1", bus.done);
    end
    wait_idle("b2b");
    check_hold("after_b2b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
